// File: rtl/mdu_unit.sv
// Multi-cycle mult/div unit owning HI/LO; MULT_CYCLES/DIV_CYCLES busy cycles, results visible the first idle cycle.
// No queueing: start while busy is dropped, hazard logic stalls on busy. Optional madd/msub family under MDU_MADD_EN.
module mdu_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    input  logic        start,
    input  logic        req,
    output logic        busy,
    output logic [31:0] out
);
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [31:0]   r_hi, r_lo, r_a, r_b;
    logic [3:0]    r_op;
    logic [CW-1:0] r_cnt;
    logic          r_busy;

    logic          w_is_mul, w_is_div, w_launch, w_move, w_done;
    logic [63:0]   w_prod_s, w_prod_u;
    logic          w_sdiv, w_a_neg, w_b_neg;
    logic [31:0]   w_dvd, w_dvs, w_q_u, w_r_u, w_q, w_r;
    logic [31:0]   w_hi_nx, w_lo_nx;

`ifdef MDU_MADD_EN
    assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU) || (op >= 4'd9 && op <= 4'd12);
`else
    assign w_is_mul = (op == OP_MULT) || (op == OP_MULTU);
`endif
    assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
    assign w_launch = start && !req && !r_busy && (w_is_mul || w_is_div);
    assign w_move   = !req && !r_busy && (op == OP_MTHI || op == OP_MTLO);
    assign w_done   = r_busy && (r_cnt == CW'(1));

    assign w_prod_s = $signed({{32{r_a[31]}}, r_a}) * $signed({{32{r_b[31]}}, r_b});
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide on magnitudes; this also yields 0x80000000/-1 = 0x80000000 rem 0.
    assign w_sdiv  = (r_op == OP_DIV);
    assign w_a_neg = w_sdiv && r_a[31];
    assign w_b_neg = w_sdiv && r_b[31];
    assign w_dvd   = w_a_neg ? (32'd0 - r_a) : r_a;
    assign w_dvs   = w_b_neg ? (32'd0 - r_b) : r_b;
    assign w_q_u   = w_dvd / ((w_dvs == 32'd0) ? 32'd1 : w_dvs);
    assign w_r_u   = w_dvd % ((w_dvs == 32'd0) ? 32'd1 : w_dvs);
    assign w_q     = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_u) : w_q_u;
    assign w_r     = w_a_neg ? (32'd0 - w_r_u) : w_r_u;

    always_comb begin
        w_hi_nx = r_hi;
        w_lo_nx = r_lo;
        case (r_op)
            OP_MULT:  {w_hi_nx, w_lo_nx} = w_prod_s;
            OP_MULTU: {w_hi_nx, w_lo_nx} = w_prod_u;
            OP_DIV, OP_DIVU: begin
                if (r_b != 32'd0) begin
                    w_hi_nx = w_r;
                    w_lo_nx = w_q;
                end
            end
`ifdef MDU_MADD_EN
            4'd9:  {w_hi_nx, w_lo_nx} = {r_hi, r_lo} + w_prod_s;
            4'd10: {w_hi_nx, w_lo_nx} = {r_hi, r_lo} + w_prod_u;
            4'd11: {w_hi_nx, w_lo_nx} = {r_hi, r_lo} - w_prod_s;
            4'd12: {w_hi_nx, w_lo_nx} = {r_hi, r_lo} - w_prod_u;
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
        end else if (r_busy) begin
            if (w_done) begin
                r_hi   <= w_hi_nx;
                r_lo   <= w_lo_nx;
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else begin
                r_cnt <= r_cnt - CW'(1);
            end
        end else begin
            if (w_launch) begin
                r_a    <= a;
                r_b    <= b;
                r_op   <= op;
                r_busy <= 1'b1;
                r_cnt  <= w_is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
            if (w_move && op == OP_MTHI) r_hi <= a;
            if (w_move && op == OP_MTLO) r_lo <= a;
        end
    end

    assign busy = r_busy;

    always_comb begin
        out = 32'd0;
        if (op == OP_MFHI) out = r_hi;
        if (op == OP_MFLO) out = r_lo;
    end
endmodule
